// File: rtl/alu_exec_unit_pkg.sv
// Shared definitions for the miniRISC execute-stage ALU.
package alu_exec_unit_pkg;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned OPW   = 4;
   localparam int unsigned SHW   = 5;

   localparam logic [OPW-1:0] OP_ADD  = 4'd0;
   localparam logic [OPW-1:0] OP_COMP = 4'd1;
   localparam logic [OPW-1:0] OP_AND  = 4'd2;
   localparam logic [OPW-1:0] OP_XOR  = 4'd3;
   localparam logic [OPW-1:0] OP_SHLL = 4'd4;
   localparam logic [OPW-1:0] OP_SHRL = 4'd5;
   localparam logic [OPW-1:0] OP_SHRA = 4'd6;
   localparam logic [OPW-1:0] OP_DIFF = 4'd7;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   // True for the three multi-cycle shift opcodes
   function automatic logic is_shift(input logic [OPW-1:0] o);
      return (o == OP_SHLL) || (o == OP_SHRL) || (o == OP_SHRA);
   endfunction

   // One-bit shift step for the latched shift opcode
   function automatic logic [WIDTH-1:0] shift_step(input logic [OPW-1:0] o,
                                                   input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] r;
      r = v;
      case (o)
         OP_SHLL: r = {v[WIDTH-2:0], 1'b0};
         OP_SHRL: r = {1'b0, v[WIDTH-1:1]};
         OP_SHRA: r = {v[WIDTH-1], v[WIDTH-1:1]};
         default: r = v;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/alu_exec_unit_diff.sv
// Lowest differing bit of a and b as a one-hot word (0 when a == b).
module alu_exec_unit_diff
   import alu_exec_unit_pkg::*;
(
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] diff_bit
);

   logic [WIDTH-1:0] x;

   // Isolate the least significant set bit of a^b
   always_comb begin
      x        = a ^ b;
      diff_bit = x & (~x + WIDTH'(1));
   end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ops plus bit-serial shifts, start/busy/done handshake.
module alu_exec_unit
   import alu_exec_unit_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [OPW-1:0]   op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             zero,
   output logic             sign,
   output logic             busy,
   output logic             done
);

   logic [0:0]       state, state_nxt;
   logic [WIDTH-1:0] work, work_nxt;
   logic [SHW-1:0]   cnt, cnt_nxt;
   logic [OPW-1:0]   sop, sop_nxt;
   logic [WIDTH-1:0] result_nxt;
   logic             carry_nxt, zero_nxt, sign_nxt, busy_nxt, done_nxt;

   logic [WIDTH-1:0] diff_c;
   logic [WIDTH:0]   sum_c;
   logic [WIDTH-1:0] single_c;
   logic             single_carry_c;
   logic [WIDTH-1:0] step_c;
   logic             wr_c;
   logic [WIDTH-1:0] wr_val_c;
   logic             wr_carry_c;

   alu_exec_unit_diff u_diff (
      .a        (a),
      .b        (b),
      .diff_bit (diff_c)
   );

   // Single-cycle operation mux on the live operands
   always_comb begin
      sum_c          = {1'b0, a} + {1'b0, b};
      single_c       = '0;
      single_carry_c = 1'b0;
      case (op)
         OP_ADD:  {single_carry_c, single_c} = sum_c;
         OP_COMP: single_c = ~b + WIDTH'(1);
         OP_AND:  single_c = a & b;
         OP_XOR:  single_c = a ^ b;
         OP_DIFF: single_c = diff_c;
         default: single_c = '0;
      endcase
   end

   // Next-state, datapath and output-register logic
   always_comb begin
      state_nxt  = state;
      work_nxt   = work;
      cnt_nxt    = cnt;
      sop_nxt    = sop;
      result_nxt = result;
      carry_nxt  = carry;
      zero_nxt   = zero;
      sign_nxt   = sign;
      busy_nxt   = busy;
      done_nxt   = 1'b0;
      wr_c       = 1'b0;
      wr_val_c   = '0;
      wr_carry_c = 1'b0;
      step_c     = shift_step(sop, work);

      case (state)
         ST_IDLE: begin
            if (start) begin
               if (is_shift(op)) begin
                  work_nxt = a;
                  cnt_nxt  = b[SHW-1:0];
                  sop_nxt  = op;
                  if (b[SHW-1:0] == '0) begin
                     wr_c     = 1'b1;
                     wr_val_c = a;
                  end else begin
                     state_nxt = ST_SHIFT;
                     busy_nxt  = 1'b1;
                  end
               end else begin
                  wr_c       = 1'b1;
                  wr_val_c   = single_c;
                  wr_carry_c = single_carry_c;
               end
            end
         end
         ST_SHIFT: begin
            work_nxt = step_c;
            cnt_nxt  = cnt - SHW'(1);
            if (cnt == SHW'(1)) begin
               wr_c      = 1'b1;
               wr_val_c  = step_c;
               state_nxt = ST_IDLE;
               busy_nxt  = 1'b0;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            busy_nxt  = 1'b0;
         end
      endcase

      if (wr_c) begin
         result_nxt = wr_val_c;
         carry_nxt  = wr_carry_c;
         zero_nxt   = (wr_val_c == '0);
         sign_nxt   = wr_val_c[WIDTH-1];
         done_nxt   = 1'b1;
      end
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         work   <= '0;
         cnt    <= '0;
         sop    <= '0;
         result <= '0;
         carry  <= 1'b0;
         zero   <= 1'b0;
         sign   <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_nxt;
         work   <= work_nxt;
         cnt    <= cnt_nxt;
         sop    <= sop_nxt;
         result <= result_nxt;
         carry  <= carry_nxt;
         zero   <= zero_nxt;
         sign   <= sign_nxt;
         busy   <= busy_nxt;
         done   <= done_nxt;
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit.
module tb_alu_exec_unit;
   import alu_exec_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  op = 4'd0;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic [31:0] result;
   logic        carry, zero, sign, busy, done;

   int n_cmp = 0;
   int n_bad = 0;

   alu_exec_unit dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .result (result),
      .carry  (carry),
      .zero   (zero),
      .sign   (sign),
      .busy   (busy),
      .done   (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Present an op at negedge; returns #1 after the accepting edge with start low
   task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
      @(negedge clk);
      op = o; a = x; b = y; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Wait for done; lat = edges after accept, bsy = cycles with busy high
   task automatic wait_done(input bit poke, output int lat, output int bsy);
      lat = 0; bsy = 0;
      while (!done && lat < 64) begin
         if (busy) bsy++;
         if (poke && lat == 3) begin
            start = 1'b1; op = OP_ADD; a = 32'h0; b = 32'h0;
         end
         if (poke && lat == 4) start = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      chk("done_seen", 32'(done), 32'd1);
   endtask

   logic [31:0] dv_a [5];
   logic [31:0] dv_b [5];
   logic [31:0] dv_r [5];

   initial begin
      int lat, bsy, seen;
      dv_a[0] = 32'd1;       dv_b[0] = 32'd0;       dv_r[0] = 32'd1;
      dv_a[1] = 32'd5045;    dv_b[1] = 32'd45042;   dv_r[1] = 32'd1;
      dv_a[2] = 32'd32768;   dv_b[2] = 32'd32768;   dv_r[2] = 32'd0;
      dv_a[3] = 32'd65535;   dv_b[3] = 32'd65535;   dv_r[3] = 32'd0;
      dv_a[4] = 32'd1234567; dv_b[4] = 32'd3456789; dv_r[4] = 32'd2;

      // Reset state
      #12;
      chk("rst_result", result, 32'd0);
      chk("rst_flags", {27'd0, carry, zero, sign, busy, done}, 32'd0);
      @(negedge clk); rst = 1'b0;

      // 1: reset in the middle of a long shift
      issue(OP_XOR, 32'h0000_00F0, 32'h0000_000F);
      chk("xor_pre", result, 32'h0000_00FF);
      issue(OP_SHLL, 32'd1, 32'd20);
      chk("shll_busy", 32'(busy), 32'd1);
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("midrst_result", result, 32'd0);
      chk("midrst_flags", {27'd0, carry, zero, sign, busy, done}, 32'd0);
      @(negedge clk); rst = 1'b0;
      seen = 0;
      repeat (25) begin
         @(posedge clk); #1;
         if (done || busy) seen++;
      end
      chk("dropped_op", 32'(seen), 32'd0);
      issue(OP_ADD, 32'd1, 32'd1);
      chk("add_done", 32'(done), 32'd1);
      chk("add_1_1", result, 32'd2);

      // 2: ADD overflow
      issue(OP_ADD, 32'hFFFF_FFFF, 32'd1);
      chk("ovf_done", 32'(done), 32'd1);
      chk("ovf_result", result, 32'd0);
      chk("ovf_flags", {29'd0, carry, zero, sign}, 32'b110);

      // 3: SHRA by 31 with ignored start pulses
      issue(OP_SHRA, 32'h8000_0000, 32'd31);
      wait_done(1'b1, lat, bsy);
      chk("shra_lat", 32'(lat), 32'd31);
      chk("shra_busy", 32'(bsy), 32'd31);
      chk("shra_result", result, 32'hFFFF_FFFF);
      chk("shra_flags", {29'd0, carry, zero, sign}, 32'b001);
      @(posedge clk); #1;
      chk("shra_one_pulse", {30'd0, busy, done}, 32'd0);

      // 4: zero-length shift, then SHRL by 8
      issue(OP_SHLL, 32'd5, 32'd0);
      chk("shll0_done", 32'(done), 32'd1);
      chk("shll0_busy", 32'(busy), 32'd0);
      chk("shll0_result", result, 32'd5);
      issue(OP_SHRL, 32'h100, 32'd8);
      wait_done(1'b0, lat, bsy);
      chk("shrl_lat", 32'(lat), 32'd8);
      chk("shrl_busy", 32'(bsy), 32'd8);
      chk("shrl_result", result, 32'd1);
      @(posedge clk); #1;
      chk("shrl_hold", {result[30:0], done}, {31'd1, 1'b0});

      // 5: DIFF back-to-back
      @(negedge clk);
      start = 1'b1; op = OP_DIFF;
      for (int i = 0; i < 5; i++) begin
         a = dv_a[i]; b = dv_b[i];
         @(posedge clk); #1;
         chk($sformatf("diff%0d_done", i), 32'(done), 32'd1);
         chk($sformatf("diff%0d_result", i), result, dv_r[i]);
         chk($sformatf("diff%0d_zero", i), 32'(zero), (dv_r[i] == 32'd0) ? 32'd1 : 32'd0);
      end
      start = 1'b0;

      // 6: COMP and an illegal opcode
      issue(OP_COMP, 32'd7, 32'd1);
      chk("comp_result", result, 32'hFFFF_FFFF);
      chk("comp_flags", {29'd0, carry, zero, sign}, 32'b001);
      issue(4'hF, 32'd3, 32'd5);
      chk("ill_done", 32'(done), 32'd1);
      chk("ill_result", result, 32'd0);
      chk("ill_zero", 32'(zero), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
